// File: rtl/dial_pkg.sv
// Shared constants and the S1->S2 command record for the dial coprocessor.
package dial_pkg;

  localparam logic DIR_R = 1'b0;
  localparam logic DIR_L = 1'b1;

  localparam int CTL_PASS = 0;
  localparam int CTL_CLR  = 1;
  localparam int CTL_W    = 2;

  // Widest distance field the pipeline record can carry; q and r always fit.
  localparam int CMD_W = 16;

  typedef struct packed {
    logic             valid;
    logic             dir;
    logic [CMD_W-1:0] q;
    logic [CMD_W-1:0] r;
    logic [CTL_W-1:0] ctl;
  } dial_cmd_t;

endpackage

// File: rtl/dial_step.sv
// One dial move: from position, direction, full-turn count q and remainder r,
// produce the new position, the number of clicks landing on 0, and the end-at-0 flag.
module dial_step
  import dial_pkg::*;
#(
  parameter int DIAL_SIZE = 100,
  parameter int POS_W     = 7,
  parameter int Q_W       = CMD_W
) (
  input  logic [POS_W-1:0] pos_i,
  input  logic             dir_i,
  input  logic [Q_W-1:0]   q_i,
  input  logic [Q_W-1:0]   r_i,
  output logic [POS_W-1:0] newpos_o,
  output logic [Q_W:0]     hits_o,
  output logic             at_zero_o
);

  localparam int W = Q_W + 1;
  localparam logic [W-1:0] SIZE = W'(DIAL_SIZE);

  logic [W-1:0] p;
  logic [W-1:0] r;
  logic [W-1:0] sum;
  logic [W-1:0] np;
  logic         carry;

  assign p = W'(pos_i);
  assign r = W'(r_i);

  always_comb begin
    sum   = p + r;
    np    = '0;
    carry = 1'b0;
    if (dir_i == DIR_R) begin
      if (sum >= SIZE) begin
        np    = sum - SIZE;
        carry = 1'b1;
      end else begin
        np = sum;
      end
    end else if (p == '0) begin
      // Leaving 0 to the left does not count the starting position as a click.
      np = (r == '0) ? '0 : SIZE - r;
    end else begin
      np    = (r <= p) ? p - r : p + SIZE - r;
      carry = (r >= p);
    end
  end

  assign newpos_o  = np[POS_W-1:0];
  assign hits_o    = {1'b0, q_i} + W'(carry);
  assign at_zero_o = (np == '0);

endmodule

// File: rtl/dial_coprocessor.sv
// Three-stage dial tracking coprocessor: S1 splits distance, S2 updates pos/counters, S3 registers dout.
// Optional build macro COPRO_PASSTHRU_EN: control[0] commands echo din instead of rotating.
module dial_coprocessor
  import dial_pkg::*;
#(
  parameter int WIDTH_DIN  = 128,
  parameter int WIDTH_DOUT = 128,
  parameter int DIAL_SIZE  = 100,
  parameter int DIAL_START = 50,
  parameter int DIST_W     = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [WIDTH_DIN-1:0]  din,
  input  logic                  din_valid,
  input  logic [5:0]            control,
  output logic [WIDTH_DOUT-1:0] dout,
  output logic                  dout_valid
);

  localparam int POS_W = $clog2(DIAL_SIZE);
  localparam int CNT_W = WIDTH_DOUT / 2;
  localparam logic [DIST_W-1:0] SIZE_D = DIST_W'(DIAL_SIZE);
  localparam logic [POS_W-1:0]  START  = POS_W'(DIAL_START);

  logic [DIST_W-1:0] dist_c;
  logic [DIST_W-1:0] q_c;
  logic [DIST_W-1:0] r_c;
  dial_cmd_t         s1_q;

  assign dist_c = din[DIST_W-1:0];
  assign q_c    = dist_c / SIZE_D;
  assign r_c    = dist_c % SIZE_D;

  // S1: control is captured every cycle so a soft clear works without a command.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_q <= '0;
    end else begin
      s1_q.valid <= din_valid;
      s1_q.dir   <= din[DIST_W];
      s1_q.q     <= CMD_W'(q_c);
      s1_q.r     <= CMD_W'(r_c);
      s1_q.ctl   <= control[CTL_W-1:0];
    end
  end

  logic [POS_W-1:0] pos_q;
  logic [POS_W-1:0] newpos_c;
  logic [CMD_W:0]   hits_c;
  logic             at_zero_c;
  logic [CNT_W-1:0] cnt_end_q;
  logic [CNT_W-1:0] cnt_click_q;
  logic             s2_valid_q;
  logic             pass_c;
  logic             clr_c;

  assign clr_c = s1_q.ctl[CTL_CLR];

  dial_step #(
    .DIAL_SIZE (DIAL_SIZE),
    .POS_W     (POS_W),
    .Q_W       (CMD_W)
  ) u_step (
    .pos_i     (pos_q),
    .dir_i     (s1_q.dir),
    .q_i       (s1_q.q),
    .r_i       (s1_q.r),
    .newpos_o  (newpos_c),
    .hits_o    (hits_c),
    .at_zero_o (at_zero_c)
  );

  // S2: a soft clear drops the command it travels with.
  always_ff @(posedge clk) begin
    if (rst || clr_c) begin
      pos_q       <= START;
      cnt_end_q   <= '0;
      cnt_click_q <= '0;
      s2_valid_q  <= 1'b0;
    end else begin
      s2_valid_q <= s1_q.valid;
      if (s1_q.valid && !pass_c) begin
        pos_q       <= newpos_c;
        cnt_click_q <= cnt_click_q + CNT_W'(hits_c);
        cnt_end_q   <= cnt_end_q + CNT_W'(at_zero_c);
      end
    end
  end

  logic [WIDTH_DOUT-1:0] s3_word_c;
  logic                  unused_bits;

`ifdef COPRO_PASSTHRU_EN
  logic [WIDTH_DOUT-1:0] s1_data_q;
  logic [WIDTH_DOUT-1:0] s2_data_q;
  logic                  s2_pass_q;

  assign pass_c = s1_q.ctl[CTL_PASS];

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_data_q <= '0;
    end else begin
      s1_data_q <= WIDTH_DOUT'(din);
    end
  end

  always_ff @(posedge clk) begin
    if (rst || clr_c) begin
      s2_data_q <= '0;
      s2_pass_q <= 1'b0;
    end else begin
      s2_pass_q <= s1_q.valid && pass_c;
      if (s1_q.valid) begin
        s2_data_q <= s1_data_q;
      end
    end
  end

  assign s3_word_c   = s2_pass_q ? s2_data_q : {cnt_click_q, cnt_end_q};
  assign unused_bits = ^control[5:CTL_W];
`else
  assign pass_c      = 1'b0;
  assign s3_word_c   = {cnt_click_q, cnt_end_q};
  assign unused_bits = ^{din[WIDTH_DIN-1:DIST_W+1], control[5:CTL_W], s1_q.ctl[CTL_PASS]};
`endif

  logic [WIDTH_DOUT-1:0] dout_q;
  logic                  dout_valid_q;

  // S3: dout only moves when a result is presented, otherwise it holds.
  always_ff @(posedge clk) begin
    if (rst) begin
      dout_q       <= '0;
      dout_valid_q <= 1'b0;
    end else begin
      dout_valid_q <= s2_valid_q;
      if (s2_valid_q) begin
        dout_q <= s3_word_c;
      end
    end
  end

  assign dout       = dout_q;
  assign dout_valid = dout_valid_q;

endmodule

// File: tb/tb_dial_coprocessor.sv
// Scoreboard bench for dial_coprocessor: directed commands push expected words, a monitor pops on dout_valid.
module tb_dial_coprocessor;

  logic         clk = 1'b0;
  logic         rst;
  logic [127:0] din;
  logic         din_valid;
  logic [5:0]   control;
  logic [127:0] dout;
  logic         dout_valid;

  dial_coprocessor dut (
    .clk        (clk),
    .rst        (rst),
    .din        (din),
    .din_valid  (din_valid),
    .control    (control),
    .dout       (dout),
    .dout_valid (dout_valid)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [127:0] exp_q[$];
  int           exp_cyc_q[$];
  int           n_cmp = 0;
  int           n_bad = 0;

  localparam logic [127:0] L = 128'h10000;

  function automatic logic [127:0] mk(input longint unsigned click, input longint unsigned ends);
    return {click[63:0], ends[63:0]};
  endfunction

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  // Monitor: every presented result must match the oldest expectation and arrive 3 cycles after issue.
  always @(negedge clk) begin : monitor
    logic [127:0] e;
    int           c;
    if (dout_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_valid: got dout %h with nothing expected", dout);
      end else begin
        e = exp_q.pop_front();
        c = exp_cyc_q.pop_front();
        check("dout", dout, e);
        check("latency", 128'(cyc - c), 128'd3);
      end
    end
  end

  task automatic send(input logic [127:0] d, input logic [5:0] ctl, input bit expect_out, input logic [127:0] e);
    @(posedge clk); #1;
    din       = d;
    din_valid = 1'b1;
    control   = ctl;
    if (expect_out) begin
      exp_q.push_back(e);
      exp_cyc_q.push_back(cyc);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      din_valid = 1'b0;
      control   = '0;
      din       = '0;
    end
  endtask

  task automatic do_reset();
    idle(5);
    rst = 1'b1;
    idle(2);
    rst = 1'b0;
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "timeout");
  end

  initial begin
    rst       = 1'b1;
    din       = '0;
    din_valid = 1'b0;
    control   = '0;
    idle(3);
    rst = 1'b0;
    check("reset_dout", dout, '0);
    check("reset_valid", 128'(dout_valid), 128'd0);

    // 50 -> R101 -> 51 -> R49 -> 0, then R3 with junk upper bits, then L3 back to 0
    send(128'd101, 6'd0, 1, mk(1, 0));
    send(128'd49,  6'd0, 1, mk(2, 1));
    send(128'hDEAD_BEEF_0000_0000_0000_0000_0000_0003, 6'd0, 1, mk(2, 1));
    send(L | 128'd3, 6'd0, 1, mk(3, 2));
    idle(1);
    check("hold_dout", dout, dout);
    do_reset();

    send(L | 128'd50,  6'd0, 1, mk(1, 1));
    send(L | 128'd0,   6'd0, 1, mk(1, 2));
    send(L | 128'd100, 6'd0, 1, mk(2, 3));
    do_reset();

    send(128'd1000,    6'd0, 1, mk(10, 0));
    send(L | 128'd250, 6'd0, 1, mk(13, 1));
    idle(6);
    check("dout_holds", dout, mk(13, 1));
    do_reset();

    // Soft clear rides with R5, which is dropped; R50 then starts from 50
    send(128'd150, 6'd0, 1, mk(2, 1));
    send(128'd5,   6'b000010, 0, '0);
    send(128'd50,  6'd0, 1, mk(1, 1));
    idle(6);

    // Reset while a command is in flight discards it
    send(128'd150, 6'd0, 0, '0);
    @(posedge clk); #1;
    din_valid = 1'b0;
    rst       = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("midreset_dout", dout, '0);
    send(128'd50, 6'd0, 1, mk(1, 1));
    do_reset();

`ifdef COPRO_PASSTHRU_EN
    send(128'h1234, 6'b000001, 1, 128'h1234);
    send(128'd50,   6'd0,      1, mk(1, 1));
`else
    // control[0] ignored: 0x1234 = 4660 is R4660 from 50 -> pos 10, 47 clicks
    send(128'h1234, 6'b000001, 1, mk(47, 0));
    send(128'd50,   6'd0,      1, mk(47, 0));
`endif
    idle(8);

    check("drain", 128'(exp_q.size()), 128'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
